// File: rtl/pc_seq_unit_pkg.sv
// Shared definitions for the PC sequencer: next-pc select codes and a
// ceiling-log2 helper used to size stack pointers and counters.
package pc_pkg;
    typedef logic [2:0] sel_t;

    localparam sel_t SEL_HOLD = 3'd0;
    localparam sel_t SEL_SEQ  = 3'd1;
    localparam sel_t SEL_BR   = 3'd2;
    localparam sel_t SEL_JMP  = 3'd3;
    localparam sel_t SEL_CALL = 3'd4;
    localparam sel_t SEL_RET  = 3'd5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pc_seq_unit_if.sv
// Fetch-side request/response bundle for pc_seq_unit.
interface pc_seq_unit_if #(parameter int N = 5);
    logic         stall;
    logic         branch_take;
    logic [N-1:0] branch_off;
    logic         jump;
    logic         call;
    logic         ret;
    logic [N-1:0] jump_addr;
    logic [N-1:0] pc;
    logic [N-1:0] pc_plus1;
    logic         ras_full;
    logic         ras_empty;
    logic         ras_err;

    modport master (
        output stall, branch_take, branch_off, jump, call, ret, jump_addr,
        input  pc, pc_plus1, ras_full, ras_empty, ras_err
    );
    modport slave (
        input  stall, branch_take, branch_off, jump, call, ret, jump_addr,
        output pc, pc_plus1, ras_full, ras_empty, ras_err
    );
endinterface

// File: rtl/pc_seq_unit_ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// the caller guarantees push and pop are never asserted together.
module ras_stack import pc_pkg::*; #(
    parameter int N     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [N-1:0] push_data_i,
    output logic [N-1:0] top_data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         overflow_o,
    output logic         underflow_o
);
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [N-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_inc, ptr_dec;
    logic [CW-1:0] cnt_q;

    // ptr_q is the next free slot; once full it also marks the oldest entry.
    assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;

    assign top_data_o  = mem_q[ptr_dec];
    assign full_o      = (cnt_q == CW'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign overflow_o  = push_i && full_o;
    assign underflow_o = pop_i && empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_inc;
            if (!full_o) cnt_q <= cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter: stride increment, relative branch, absolute
// jump and call/return through an internal return-address stack.
module pc_seq_unit import pc_pkg::*; #(
    parameter int N        = 5,
    parameter int STEP     = 1,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_seq_unit_if.slave  bus
);
    logic [N-1:0] pc_q, pc_d, pc_plus1, top_data;
    logic         ras_err_q, ras_err_d;
    logic         push, pop, full, empty, ovf, unf;
    sel_t         sel;

    assign pc_plus1 = pc_q + N'(STEP);

    always_comb begin
        sel  = SEL_SEQ;
        push = 1'b0;
        pop  = 1'b0;
        if (bus.stall) begin
            sel = SEL_HOLD;
        end else if (bus.call && bus.ret) begin
            sel = SEL_SEQ;
        end else if (bus.ret) begin
            pop = 1'b1;
            sel = empty ? SEL_SEQ : SEL_RET;
        end else if (bus.call) begin
            push = 1'b1;
            sel  = SEL_CALL;
        end else if (bus.jump) begin
            sel = SEL_JMP;
        end else if (bus.branch_take) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_d = pc_plus1;
        case (sel)
            SEL_HOLD: pc_d = pc_q;
            SEL_BR:   pc_d = pc_q + bus.branch_off;
            SEL_JMP,
            SEL_CALL: pc_d = bus.jump_addr;
            SEL_RET:  pc_d = top_data;
            default:  pc_d = pc_plus1;
        endcase
    end

    assign ras_err_d = !bus.stall && ((bus.call && bus.ret) || ovf || unf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= N'(RESET_PC);
            ras_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ras_err_q <= ras_err_d;
        end
    end

    ras_stack #(.N(N), .DEPTH(DEPTH)) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_plus1),
        .top_data_o  (top_data),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_plus1;
    assign bus.ras_full  = full;
    assign bus.ras_empty = empty;
    assign bus.ras_err   = ras_err_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed vector bench for pc_seq_unit (N=5, STEP=1, DEPTH=4, RESET_PC=0).
module tb_pc_seq_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_seq_unit_if #(.N(5)) bus ();

    pc_seq_unit #(.N(5), .STEP(1), .DEPTH(4), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, br, jmp, cl, rt;
        logic [4:0] off, addr;
        logic [4:0] pc;
        logic       full, empty, err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, br, input logic [4:0] off,
                       input logic jmp, cl, rt, input logic [4:0] addr,
                       input logic [4:0] pc, input logic full, empty, err);
        vec_t v;
        v.st = st; v.br = br; v.off = off; v.jmp = jmp; v.cl = cl; v.rt = rt;
        v.addr = addr; v.pc = pc; v.full = full; v.empty = empty; v.err = err;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.stall = v.st; bus.branch_take = v.br; bus.branch_off = v.off;
        bus.jump = v.jmp; bus.call = v.cl; bus.ret = v.rt; bus.jump_addr = v.addr;
    endtask

    task automatic check(input string name, input int idx, input logic [4:0] pc,
                         input logic full, empty, err);
        logic [4:0] p1;
        p1 = pc + 5'd1;
        n_cmp++;
        if (bus.pc !== pc || bus.pc_plus1 !== p1 || bus.ras_full !== full ||
            bus.ras_empty !== empty || bus.ras_err !== err) begin
            n_bad++;
            $display("FAIL %s[%0d]: got pc=%0d p1=%0d full=%0b empty=%0b err=%0b want pc=%0d p1=%0d full=%0b empty=%0b err=%0b",
                     name, idx, bus.pc, bus.pc_plus1, bus.ras_full, bus.ras_empty, bus.ras_err,
                     pc, p1, full, empty, err);
        end
    endtask

    task automatic step(input string name, input int idx, input vec_t v);
        drive(v);
        @(posedge clk);
        #1 check(name, idx, v.pc, v.full, v.empty, v.err);
    endtask

    initial begin
        vec_t z;
        z = '{default: '0};
        // st br off j c r addr -> pc full empty err
        // sequential run and wrap
        add(0,0,0, 0,0,0, 0,  1, 0,1,0);
        add(0,0,0, 0,0,0, 0,  2, 0,1,0);
        add(0,0,0, 0,0,0, 0,  3, 0,1,0);
        add(0,0,0, 1,0,0, 30, 30,0,1,0);
        add(0,0,0, 0,0,0, 0,  31,0,1,0);
        add(0,0,0, 0,0,0, 0,  0, 0,1,0);
        // branches
        add(0,0,0, 1,0,0, 10, 10,0,1,0);
        add(0,1,29,0,0,0, 0,  7, 0,1,0);
        add(0,0,0, 1,0,0, 10, 10,0,1,0);
        add(0,1,25,0,0,0, 0,  3, 0,1,0);
        add(0,0,0, 1,0,0, 10, 10,0,1,0);
        add(0,1,3, 1,0,0, 20, 20,0,1,0);
        // call / return
        add(0,0,0, 1,0,0, 4,  4, 0,1,0);
        add(0,0,0, 0,1,0, 20, 20,0,0,0);
        add(0,0,0, 0,0,0, 0,  21,0,0,0);
        add(0,0,0, 0,0,0, 0,  22,0,0,0);
        add(0,0,0, 0,0,1, 0,  5, 0,1,0);
        // overflow then underflow
        add(0,0,0, 1,0,0, 0,  0, 0,1,0);
        add(0,0,0, 0,1,0, 16, 16,0,0,0);
        add(0,0,0, 0,1,0, 16, 16,0,0,0);
        add(0,0,0, 0,1,0, 16, 16,0,0,0);
        add(0,0,0, 0,1,0, 16, 16,1,0,0);
        add(0,0,0, 0,1,0, 16, 16,1,0,1);
        add(0,0,0, 0,0,1, 0,  17,0,0,0);
        add(0,0,0, 0,0,1, 0,  17,0,0,0);
        add(0,0,0, 0,0,1, 0,  17,0,0,0);
        add(0,0,0, 0,0,1, 0,  17,0,1,0);
        add(0,0,0, 0,0,1, 0,  18,0,1,1);
        add(0,0,0, 0,0,0, 0,  19,0,1,0);
        // stall holds everything, then branch proceeds
        add(0,0,0, 1,0,0, 8,  8, 0,1,0);
        add(1,1,4, 0,0,0, 0,  8, 0,1,0);
        add(1,1,4, 0,0,0, 0,  8, 0,1,0);
        add(1,1,4, 0,0,0, 0,  8, 0,1,0);
        add(0,1,4, 0,0,0, 0,  12,0,1,0);
        // call+ret conflict, stall clears the error pulse
        add(0,0,0, 0,1,1, 5,  13,0,1,1);
        add(1,0,0, 0,0,0, 0,  13,0,1,0);
        // two entries pushed, pc=20 ahead of async reset
        add(0,0,0, 0,1,0, 20, 20,0,0,0);
        add(0,0,0, 0,1,0, 20, 20,0,0,0);

        rst_n = 1'b0;
        drive(z);
        repeat (2) @(posedge clk);
        #3 check("in_reset", 0, 5'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        check("after_release", 0, 5'd0, 1'b0, 1'b1, 1'b0);

        foreach (vq[i]) step("vec", i, vq[i]);

        // asynchronous reset asserted between edges
        #3 rst_n = 1'b0;
        #1 check("async_rst", 0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        z.rt = 1'b1; z.pc = 5'd1; z.empty = 1'b1; z.err = 1'b1;
        step("post_rst_ret", 0, z);
        z.rt = 1'b0; z.pc = 5'd2; z.err = 1'b0;
        step("post_rst_idle", 0, z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer for the pipelined core. It replaces the bare PC+1 adder with a registered PC that supports a configurable increment stride, PC-relative branches, absolute jumps, and call/return through a small internal return-address stack (RAS). It sits in the fetch stage and drives the instruction-memory address.

Parameters:
N, 5, address width in bits
STEP, 1, sequential increment added to pc each normal cycle
DEPTH, 4, return-address stack entries (>=1)
RESET_PC, 0, pc value loaded on reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold pc and stack; all other requests ignored
branch_take  in  1  take PC-relative branch this cycle
branch_off  in  N  signed branch offset (two's complement)
jump  in  1  absolute jump to jump_addr
call  in  1  push return address, then jump to jump_addr
ret  in  1  pop return address into pc
jump_addr  in  N  absolute target for jump/call
pc  out  N  current program counter (registered)
pc_plus1  out  N  pc+STEP, combinational, modulo 2^N
ras_full  out  1  stack count == DEPTH (combinational from state)
ras_empty  out  1  stack count == 0 (combinational from state)
ras_err  out  1  registered one-cycle pulse on overflow, underflow or call+ret conflict

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, stack count=0, top pointer=0, ras_err=0; held while rst_n low; first update on first rising edge after release.
- All updates on rising clk; a request sampled in cycle k is visible on pc after that edge (latency 1).
- Arithmetic: all sums modulo 2^N, no saturation. branch target = pc + branch_off (signed, N bits); sequential = pc + STEP.
- Next-pc priority, highest first:
  1. stall: pc, stack and count unchanged; ras_err <= 0.
  2. call && ret: conflict; pc <= pc+STEP, stack unchanged, ras_err <= 1.
  3. ret: if not empty, pc <= top entry, count-1. If empty (underflow), pc <= pc+STEP, ras_err <= 1.
  4. call: push pc+STEP, pc <= jump_addr. If full (overflow), the oldest entry is overwritten (circular), count stays DEPTH, ras_err <= 1.
  5. jump: pc <= jump_addr.
  6. branch_take: pc <= pc + branch_off.
  7. otherwise: pc <= pc+STEP.
- ras_err is 0 in every cycle without an error condition; it is never sticky.
- Stack is circular: top pointer wraps mod DEPTH on push and pop. With DEPTH=1, every push when full replaces the single entry.
- Lower-priority requests coincident with a higher one are dropped. They are not queued.
- pc_plus1 always reflects the current registered pc, including during stall.

Decomposition:
- Shared package pc_pkg: localparams for the next-pc select encoding (SEL_HOLD, SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET) and a ceiling-log2 function for pointer/count widths.
- One sub-module ras_stack, parametrised by N and DEPTH:
  - Inputs: push, pop, push_data.
  - Outputs: top_data, full, empty, overflow, underflow.
  - Behaviour: circular storage, count, and pointer logic.
- Priority selection and pc register live in pc_seq_unit.

Test Plan:
(N=5, STEP=1, DEPTH=4, RESET_PC=0)
1. Sequential run and wrap: release reset, idle -> pc 0,1,2,3 on successive edges; force run to pc=31 -> next pc=0; pc_plus1 tracks pc+1 (31 -> 0).
2. Branch at pc=10:
   - off=5'b11101 (-3) -> pc=7.
   - From pc=10, off=25 -> pc=3 (wrap).
   - branch_take with jump=1, jump_addr=20 -> pc=20 (jump wins).
3. Call/return: at pc=4, call with jump_addr=20 -> pc=20, ras_empty=0; two idle cycles (pc=22); ret -> pc=5, ras_empty=1, ras_err=0.
4. Overflow/underflow, from pc=0 with jump_addr=16:
   - Five back-to-back calls -> pushed returns 1,17,17,17,17, ras_full=1 after 4th, ras_err pulses only after 5th.
   - Four rets -> pc=17 each time (oldest entry 1 overwritten), then ras_empty=1.
   - Fifth ret -> ras_err=1 pulse, pc=18.
5. Stall: at pc=8 hold stall=1 with branch_take=1, off=4 for 3 cycles -> pc stays 8, pc_plus1=9, no ras change; drop stall with branch still set -> pc=12.
6. Async reset mid-operation:
   - With 2 entries pushed and pc=20, pulse rst_n low between edges -> pc=0 immediately (before next edge), ras_empty=1, ras_err=0.
   - After release, ret -> underflow pulse, pc=1.
